gemm_operand_loader: RTL and testbench

GEMM_OPERAND_LOADER -- requirements
Module: gemm_operand_loader

---
 rtl/gemm_operand_loader.sv | 166 ++++++++++++++++
 tb/tb_gemm_operand_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gemm_operand_loader.sv
// gemm_operand_loader: collects a serial operand stream (alpha, beta, A, B, C)
// into held scalar and row-major matrix registers for a downstream GEMM core.
// A full set is presented on mats_valid until the consumer takes it.
module gemm_operand_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  input  logic                  consume,
  output logic                  mats_valid,
  output logic [DATA_WIDTH-1:0] alpha,
  output logic [DATA_WIDTH-1:0] beta,
  output logic [DATA_WIDTH-1:0] a_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic [DATA_WIDTH-1:0] b_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic [DATA_WIDTH-1:0] c_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1]
);

  // Column counter must also index the two scalars, so it is at least 1 bit.
  localparam int CW = (MATRIX_WIDTH > 2) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);

  typedef enum logic [2:0] {
    LOAD_SCALARS = 3'd0,
    LOAD_A       = 3'd1,
    LOAD_B       = 3'd2,
    LOAD_C       = 3'd3,
    FULL         = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            w_accept;
  logic            w_last_elem;
  logic            w_state_change;

  logic [DATA_WIDTH-1:0] r_alpha;
  logic [DATA_WIDTH-1:0] r_beta;
  logic [DATA_WIDTH-1:0] r_a [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] r_b [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] r_c [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];

  // clear blocks acceptance so a flushed word never reaches the registers
  assign w_accept       = in_valid & in_ready & ~clear;
  assign w_last_elem    = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_state_change = (w_next_state != r_state);

  assign alpha    = r_alpha;
  assign beta     = r_beta;
  assign a_matrix = r_a;
  assign b_matrix = r_b;
  assign c_matrix = r_c;

  // State register
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state <= LOAD_SCALARS;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: clear overrides consume and acceptance
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = LOAD_SCALARS;
    end else begin
      case (r_state)
        LOAD_SCALARS: begin
          if (w_accept && (r_col == CW'(1))) w_next_state = LOAD_A;
          else                               w_next_state = LOAD_SCALARS;
        end
        LOAD_A: begin
          if (w_accept && w_last_elem) w_next_state = LOAD_B;
          else                         w_next_state = LOAD_A;
        end
        LOAD_B: begin
          if (w_accept && w_last_elem) w_next_state = LOAD_C;
          else                         w_next_state = LOAD_B;
        end
        LOAD_C: begin
          if (w_accept && w_last_elem) w_next_state = FULL;
          else                         w_next_state = LOAD_C;
        end
        FULL: begin
          if (consume) w_next_state = LOAD_SCALARS;
          else         w_next_state = FULL;
        end
        default: w_next_state = LOAD_SCALARS;
      endcase
    end
  end

  // Output decode: ready in every load state, valid only when the set is full
  always_comb begin
    in_ready   = 1'b1;
    mats_valid = 1'b0;
    case (r_state)
      FULL: begin
        in_ready   = 1'b0;
        mats_valid = 1'b1;
      end
      default: begin
        in_ready   = 1'b1;
        mats_valid = 1'b0;
      end
    endcase
  end

  // Element index: row-major walk, restarted on every state change
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear || w_state_change) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_state == LOAD_SCALARS) begin
        r_col <= r_col + CW'(1);
      end else if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Operand registers: written only by their own accepted word, else held
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_alpha <= '0;
      r_beta  <= '0;
      for (int r = 0; r < MATRIX_HEIGHT; r++) begin
        for (int c = 0; c < MATRIX_WIDTH; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
          r_c[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      case (r_state)
        LOAD_SCALARS: begin
          if (r_col == CW'(0)) r_alpha <= in_data;
          else                 r_beta  <= in_data;
        end
        LOAD_A:  r_a[r_row][r_col] <= in_data;
        LOAD_B:  r_b[r_row][r_col] <= in_data;
        LOAD_C:  r_c[r_row][r_col] <= in_data;
        default: r_alpha <= r_alpha;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Self-checking bench for gemm_operand_loader (default 32-bit, 4x4 parameters).
module tb_gemm_operand_loader;

  logic        iclk = 1'b0;
  logic        irst = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clear = 1'b0;
  logic        consume = 1'b0;
  logic        mats_valid;
  logic [31:0] alpha, beta;
  logic [31:0] a_m [0:3][0:3];
  logic [31:0] b_m [0:3][0:3];
  logic [31:0] c_m [0:3][0:3];

  int checks = 0;
  int failures = 0;

  gemm_operand_loader #(.DATA_WIDTH(32), .MATRIX_WIDTH(4), .MATRIX_HEIGHT(4)) dut (
    .iclk(iclk), .irst(irst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .consume(consume),
    .mats_valid(mats_valid), .alpha(alpha), .beta(beta),
    .a_matrix(a_m), .b_matrix(b_m), .c_matrix(c_m)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] d;
    logic        clr;
    logic        cons;
    logic        exp_rdy;
    logic        exp_mv;
    logic [31:0] exp_alpha;
    logic [31:0] exp_beta;
    logic [31:0] exp_a00;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(string n, logic v, logic [31:0] d, logic clr, logic cons,
                              logic rdy, logic mv, logic [31:0] ea, logic [31:0] eb,
                              logic [31:0] e00);
    vec_t t;
    t.name = n; t.v = v; t.d = d; t.clr = clr; t.cons = cons;
    t.exp_rdy = rdy; t.exp_mv = mv; t.exp_alpha = ea; t.exp_beta = eb; t.exp_a00 = e00;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic send(logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Streams one full set base..base+49, optionally with idle gaps.
  task automatic load_set(int base, bit gaps);
    for (int i = 0; i < 50; i++) begin
      if (gaps && (i == 10 || $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        tick();
      end
      if (i == 49) check("mv_before_last", {31'd0, mats_valid}, 32'd0);
      send(32'(base + i));
    end
    check("mv_after_last", {31'd0, mats_valid}, 32'd1);
    check("rdy_full", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_set(int base);
    check("alpha", alpha, 32'(base));
    check("beta", beta, 32'(base + 1));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check("a_elem", a_m[r][c], 32'(base + 2 + r * 4 + c));
        check("b_elem", b_m[r][c], 32'(base + 18 + r * 4 + c));
        check("c_elem", c_m[r][c], 32'(base + 34 + r * 4 + c));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk("full_hold0", 1'b1, 32'd999, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,   32'd2,   32'd3);
    tbl[1]  = mk("full_hold1", 1'b1, 32'd999, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,   32'd2,   32'd3);
    tbl[2]  = mk("full_hold2", 1'b1, 32'd999, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,   32'd2,   32'd3);
    tbl[3]  = mk("full_hold3", 1'b1, 32'd999, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,   32'd2,   32'd3);
    tbl[4]  = mk("full_hold4", 1'b1, 32'd999, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1,   32'd2,   32'd3);
    tbl[5]  = mk("consume",    1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 32'd1,   32'd2,   32'd3);
    tbl[6]  = mk("new_alpha",  1'b1, 32'd101, 1'b0, 1'b0, 1'b1, 1'b0, 32'd101, 32'd2,   32'd3);
    tbl[7]  = mk("cons_scal",  1'b1, 32'd102, 1'b0, 1'b1, 1'b1, 1'b0, 32'd101, 32'd102, 32'd3);
    tbl[8]  = mk("cons_loada", 1'b1, 32'd555, 1'b0, 1'b1, 1'b1, 1'b0, 32'd101, 32'd102, 32'd555);
    tbl[9]  = mk("clr_word",   1'b1, 32'd777, 1'b1, 1'b0, 1'b1, 1'b0, 32'd101, 32'd102, 32'd555);
    tbl[10] = mk("after_clr",  1'b1, 32'd42,  1'b0, 1'b0, 1'b1, 1'b0, 32'd42,  32'd102, 32'd555);
    tbl[11] = mk("clr_idle",   1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 32'd42,  32'd102, 32'd555);

    // Reset state
    irst = 1'b1;
    #13;
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_mv", {31'd0, mats_valid}, 32'd0);
    check("rst_alpha", alpha, 32'd0);
    check("rst_c33", c_m[3][3], 32'd0);
    irst = 1'b0;
    tick();

    // Gap-free load of words 1..50
    load_set(1, 1'b0);
    check_set(1);

    // FULL hold, consume, consume ignored while loading, clear with a word
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      clear    = tbl[i].clr;
      consume  = tbl[i].cons;
      tick();
      in_valid = 1'b0; clear = 1'b0; consume = 1'b0;
      check({tbl[i].name, "_rdy"}, {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      check({tbl[i].name, "_mv"}, {31'd0, mats_valid}, {31'd0, tbl[i].exp_mv});
      check({tbl[i].name, "_alpha"}, alpha, tbl[i].exp_alpha);
      check({tbl[i].name, "_beta"}, beta, tbl[i].exp_beta);
      check({tbl[i].name, "_a00"}, a_m[0][0], tbl[i].exp_a00);
    end

    // Load with random gaps must give the same arrays
    load_set(200, 1'b1);
    check_set(200);

    // consume and clear together in FULL: flush without touching outputs
    consume = 1'b1; clear = 1'b1;
    tick();
    consume = 1'b0; clear = 1'b0;
    check("cc_rdy", {31'd0, in_ready}, 32'd1);
    check("cc_mv", {31'd0, mats_valid}, 32'd0);
    check("cc_alpha", alpha, 32'd200);
    send(32'd300);
    check("cc_next_alpha", alpha, 32'd300);
    check("cc_beta_kept", beta, 32'd201);

    // clear coinciding with the word for B[1][2]
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 24; i++) send(32'(400 + i));
    check("b11_written", b_m[1][1], 32'd423);
    in_valid = 1'b1; in_data = 32'd424; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    check("b12_not_written", b_m[1][2], 32'd224);
    send(32'd500);
    check("clr_alpha", alpha, 32'd500);
    check("clr_b12_kept", b_m[1][2], 32'd224);
    check("clr_a00_kept", a_m[0][0], 32'd402);
    check("clr_a33_kept", a_m[3][3], 32'd417);

    // Asynchronous reset in the middle of LOAD_C
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 37; i++) send(32'(600 + i));
    check("c02_loaded", c_m[0][2], 32'd636);
    #3;
    irst = 1'b1;
    #1;
    check("arst_alpha", alpha, 32'd0);
    check("arst_a00", a_m[0][0], 32'd0);
    check("arst_b33", b_m[3][3], 32'd0);
    check("arst_c02", c_m[0][2], 32'd0);
    check("arst_mv", {31'd0, mats_valid}, 32'd0);
    check("arst_rdy", {31'd0, in_ready}, 32'd1);
    #1;
    irst = 1'b0;
    send(32'd7);
    check("post_rst_alpha", alpha, 32'd7);
    check("post_rst_a00", a_m[0][0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
